// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with valid/ready handshakes on both sides.
//
// Sits between decode/issue and writeback. It accepts one op per cycle and
// registers the result together with the {N,Z,C,V} flags. Single-cycle ops
// produce their result on the edge that accepts them, so with no backpressure
// the block sustains one result per cycle.
//
// Build option:
//   ALU_SEQ_MUL_EN  When defined, op 9 (MUL) runs a WIDTH-cycle shift-add
//                   multiplier. While it runs, busy is high and in_ready is
//                   low. When undefined, the multiplier and its state are
//                   left out: op 9 behaves like an undefined op and busy is
//                   tied low.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 4)
//   SHW        (local) number of low bits of b used as the shift amount
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   op/a/b are valid this cycle
//   in_ready   an op is accepted this cycle
//   op         0 NAND, 1 AND, 2 NOR, 3 OR, 4 ADD, 5 SUB, 6 XOR, 7 SL, 8 SR,
//              9 MUL; 10-15 give out=0 with Z set
//   a, b       operands; the shift amount is b[SHW-1:0]
//   out_valid  out/flags hold a result
//   out_ready  the consumer takes the result this cycle
//   out        registered result
//   flags      {N,Z,C,V}, registered together with out
//   busy       the multiplier is iterating
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH) + 1;

    typedef enum logic [3:0] {
        OP_NAND = 4'd0,
        OP_AND  = 4'd1,
        OP_NOR  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_XOR  = 4'd6,
        OP_SL   = 4'd7,
        OP_SR   = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    // Packs the flag vector. N and Z always come from the result; C and V
    // depend on the op and are supplied by the caller.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic             c,
                                              input logic             v);
        return {res[WIDTH-1], (res == '0), c, v};
    endfunction

    // -------------------------------------------------------------------------
    // Single-cycle datapath
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [SHW-1:0]   shamt;
    logic             shift_oor;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;
    logic             accept;

    // The subtract is a + ~b + 1 with one extra bit. That top bit is the
    // carry, so it is 1 exactly when no borrow occurs (a >= b unsigned).
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // The shift amount field can reach 2*WIDTH-1. Any amount of WIDTH or
    // more empties the word, for both logical shift directions.
    assign shamt     = b[SHW-1:0];
    assign shift_oor = (shamt >= SHW'(WIDTH));

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case. Otherwise a path that skips an assignment infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_NAND: alu_res = ~(a & b);
            OP_AND:  alu_res = a & b;
            OP_NOR:  alu_res = ~(a | b);
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                // Overflow: the operands share a sign and the result does not.
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                // Overflow: the operands differ in sign and the result's sign
                // does not match the minuend's.
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SL:   alu_res = shift_oor ? '0 : (a << shamt);
            OP_SR:   alu_res = shift_oor ? '0 : (a >> shamt);
            // MUL, when built, is handled by the sequencer below. Otherwise
            // it falls through with the undefined ops: result zero, Z set.
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = make_flags(alu_res, alu_c, alu_v);

`ifdef ALU_SEQ_MUL_EN
    // -------------------------------------------------------------------------
    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    // -------------------------------------------------------------------------
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;     // multiplicand, moves left one place per step
    logic [WIDTH-1:0]   mplier;    // multiplier, moves right; bit 0 is the current bit
    logic [2*WIDTH-1:0] acc_next;
    logic [3:0]         mul_flags;

    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // Flags are computed from acc_next, not acc, so the last step's partial
    // product is included when the result loads on the final cycle.
    assign mul_flags = make_flags(acc_next[WIDTH-1:0],
                                  |acc_next[2*WIDTH-1:WIDTH], 1'b0);

    // A new op is accepted only when the output slot is free or is being
    // drained this cycle. This keeps a held result frozen under backpressure.
    assign in_ready  = !rst && (state == S_IDLE) && (!out_valid || out_ready);
`else
    assign in_ready  = !rst && (!out_valid || out_ready);
    assign busy      = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Sequencer and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state     <= S_IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments. Every
            // register therefore samples pre-edge values, and the result load
            // below can override the drain on the same edge.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

`ifdef ALU_SEQ_MUL_EN
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state  <= S_MUL;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                        end else begin
                            out       <= alu_res;
                            flags     <= alu_flags;
                            out_valid <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // in_ready was low for the whole multiply. out_valid
                        // is therefore already clear, and the slot is free.
                        out       <= acc_next[WIDTH-1:0];
                        flags     <= mul_flags;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
`else
            if (accept) begin
                out       <= alu_res;
                flags     <= alu_flags;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 16).
//
// Expected results come from a behavioural model that works on integers: mod
// 2^WIDTH arithmetic, signed range checks for overflow, and a multiply. The
// DUT's output is compared against that model. The expected multiply timing
// follows ALU_SEQ_MUL_EN, so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int WIDTH = 16;
    localparam int SHW   = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             busy;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {out, N, Z, C, V}.
    function automatic logic [WIDTH+3:0] model(input logic [3:0]       o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        longint m, ux, uy, sx, sy, r, s, t;
        logic c, v;
        logic [WIDTH-1:0] res;
        m  = longint'(1) << WIDTH;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        s  = uy % (longint'(1) << SHW);
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            4'd0: r = longint'(~(x & y));
            4'd1: r = longint'(x & y);
            4'd2: r = longint'(~(x | y));
            4'd3: r = longint'(x | y);
            4'd4: begin
                r = ux + uy;
                t = sx + sy;
                c = (r >= m);
                v = (t >= m / 2) || (t < -(m / 2));
            end
            4'd5: begin
                r = ux - uy;
                t = sx - sy;
                c = (ux >= uy);
                v = (t >= m / 2) || (t < -(m / 2));
            end
            4'd6: r = longint'(x ^ y);
            4'd7: r = (s >= WIDTH) ? 0 : (ux << s);
            4'd8: r = (s >= WIDTH) ? 0 : (ux >> s);
`ifdef ALU_SEQ_MUL_EN
            4'd9: begin
                r = ux * uy;
                c = (r >= m);
            end
`endif
            default: r = 0;
        endcase
        res = WIDTH'(((r % m) + m) % m);
        return {res, res[WIDTH-1], (res == '0), c, v};
    endfunction

    // Edges after the accepting edge until the result is visible.
    function automatic int exp_latency(input logic [3:0] o);
`ifdef ALU_SEQ_MUL_EN
        return (o == 4'd9) ? WIDTH : 0;
`else
        return (o == 4'd9) ? 0 : 0;
`endif
    endfunction

    // Offer one op and wait (bounded) until it is taken. On return, the
    // accepting edge has just passed (sampled 1 ns later) and in_valid is low.
    task automatic accept_only(input logic [3:0] o, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input string tag);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // These values must be ignored while in_valid is low.
        op = 4'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
    endtask

    // Full transaction with out_ready high. Checks latency, busy while
    // waiting, and the result against the model.
    task automatic do_op(input logic [3:0] o, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input string tag);
        logic [WIDTH+3:0] e;
        int n;
        e = model(o, x, y);
        accept_only(o, x, y, tag);
        n = 0;
        while (!out_valid && n < 100) begin
            check({tag, "_busy"}, busy, 1'b1);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, exp_latency(o));
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, e[WIDTH+3:4]);
        check({tag, "_flags"}, flags, e[3:0]);
        check({tag, "_busy_done"}, busy, 1'b0);
    endtask

    logic [3:0]       single_ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                          4'd7, 4'd8, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    logic [WIDTH+3:0] e_hold;
    logic [WIDTH+3:0] e_q [$];
    logic [3:0]       ro;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, '0);
        check("rst_flags", flags, 4'b0000);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // ---- directed boundary cases ----
        do_op(4'd4, 16'h7FFF, 16'h0001, "add_ovf");
        check("add_ovf_k_out", out, 16'h8000);
        check("add_ovf_k_flags", flags, 4'b1001);
        do_op(4'd5, 16'h0005, 16'h0005, "sub_eq");
        check("sub_eq_k_flags", flags, 4'b0110);
        do_op(4'd5, 16'h0000, 16'h0001, "sub_borrow");
        check("sub_borrow_k_out", out, 16'hFFFF);
        do_op(4'd7, 16'h0001, 16'd15, "sl15");
        check("sl15_k_out", out, 16'h8000);
        do_op(4'd7, 16'h0001, 16'd16, "sl16");
        check("sl16_k_flags", flags, 4'b0100);
        do_op(4'd8, 16'h8000, 16'd31, "sr31");
        do_op(4'd12, 16'h1234, 16'h5678, "undef12");
        check("undef12_k_flags", flags, 4'b0100);
        do_op(4'd9, 16'h00FF, 16'h0101, "mul_a");
        do_op(4'd9, 16'h0100, 16'h0100, "mul_b");
`ifdef ALU_SEQ_MUL_EN
        check("mul_b_k_flags", flags, 4'b0110);
`else
        check("mul_b_k_flags", flags, 4'b0100);
`endif

        // ---- backpressure ----
        @(posedge clk); #1;
        check("bp_idle", out_valid, 1'b0);
        out_ready = 1'b0;
        e_hold = model(4'd4, 16'h1234, 16'h1111);
        accept_only(4'd4, 16'h1234, 16'h1111, "bp_add");
        check("bp_add_valid", out_valid, 1'b1);
        op = 4'd6; a = 16'hA5A5; b = 16'h0FF0; in_valid = 1'b1;
        #1;
        check("bp_xor_blocked", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_out", out, e_hold[WIDTH+3:4]);
        check("bp_hold_flags", flags, e_hold[3:0]);
        check("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        e_hold = model(4'd6, 16'hA5A5, 16'h0FF0);
        @(posedge clk); #1;
        check("bp_xor_valid", out_valid, 1'b1);
        check("bp_xor_out", out, e_hold[WIDTH+3:4]);
        // Four back-to-back single-cycle ops, one result per cycle.
        for (int i = 0; i < 4; i++) begin
            ro = single_ops[$urandom_range(0, 13)];
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            e_q.push_back(model(ro, ra, rb));
            op = ro; a = ra; b = rb;
            @(posedge clk); #1;
            e_hold = e_q.pop_front();
            check($sformatf("b2b%0d_valid", i), out_valid, 1'b1);
            check($sformatf("b2b%0d_out", i), out, e_hold[WIDTH+3:4]);
            check($sformatf("b2b%0d_flags", i), flags, e_hold[3:0]);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", out_valid, 1'b0);

        // ---- randomized ops against the model ----
        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (i % 4 == 0) ra = WIDTH'($urandom_range(0, 3)) << (WIDTH - 2);
            do_op(ro, ra, rb, $sformatf("rnd%0d_op%0d", i, ro));
        end

        // ---- reset while an op is in flight ----
        @(posedge clk); #1;
`ifdef ALU_SEQ_MUL_EN
        accept_only(4'd9, 16'h1234, 16'h4321, "abort_mul");
`else
        out_ready = 1'b0;
        accept_only(4'd4, 16'h1234, 16'h4321, "abort_add");
`endif
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out", out, '0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        // Leave extra cycles: an aborted multiply must not deliver late.
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            check("abort_no_result", out_valid, 1'b0);
        end
        do_op(4'd4, 16'h0002, 16'h0003, "after_abort");
        check("after_abort_k_out", out, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
